// File: rtl/alu_muldiv_ctl.sv
// ALU control decoder with a HI/LO multiply/divide sequencer.
// Decodes the main-decoder op control and the R-type function field into an
// ALU operation code. It also runs a bit-serial unsigned multiplier (MULTU)
// and, optionally, a restoring divider (DIVU), both writing HI/LO. A HI/LO
// instruction issued while the sequencer is busy stalls the front end.
// Optional feature macro: ALU_MULDIV_DIV_EN (define to include the divider).
module alu_muldiv_ctl #(
    parameter int NB_OPE        = 5,
    parameter int NB_ALU_OP_CTL = 4,
    parameter int NB_FUNCTION   = 6,
    parameter int NB_DATA       = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NB_ALU_OP_CTL-1:0] i_alu_op_ctl,
    input  logic [NB_FUNCTION-1:0]   i_function,
    input  logic                     i_valid,
    input  logic [NB_DATA-1:0]       i_data_a,
    input  logic [NB_DATA-1:0]       i_data_b,
    output logic [NB_OPE-1:0]        o_alu,
    output logic                     o_hilo_sel,
    output logic [NB_DATA-1:0]       o_hilo,
    output logic                     o_stall,
    output logic                     o_busy
);

    // Main-decoder op control encodings
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_ADD  = NB_ALU_OP_CTL'(4'b0000);
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_SUB  = NB_ALU_OP_CTL'(4'b0001);
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_FUNC = NB_ALU_OP_CTL'(4'b0010);
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_ANDI = NB_ALU_OP_CTL'(4'b0100);
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_ORI  = NB_ALU_OP_CTL'(4'b0101);
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_XORI = NB_ALU_OP_CTL'(4'b0110);
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_LUI  = NB_ALU_OP_CTL'(4'b0111);
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_SLTI = NB_ALU_OP_CTL'(4'b1000);
    localparam logic [NB_ALU_OP_CTL-1:0] CTL_JAL  = NB_ALU_OP_CTL'(4'b1001);

    // ALU operation codes
    localparam logic [NB_OPE-1:0] ALU_AND  = NB_OPE'(5'd0);
    localparam logic [NB_OPE-1:0] ALU_OR   = NB_OPE'(5'd1);
    localparam logic [NB_OPE-1:0] ALU_ADD  = NB_OPE'(5'd2);
    localparam logic [NB_OPE-1:0] ALU_XOR  = NB_OPE'(5'd3);
    localparam logic [NB_OPE-1:0] ALU_SUB  = NB_OPE'(5'd6);
    localparam logic [NB_OPE-1:0] ALU_SLT  = NB_OPE'(5'd7);
    localparam logic [NB_OPE-1:0] ALU_SLL  = NB_OPE'(5'd8);
    localparam logic [NB_OPE-1:0] ALU_SRL  = NB_OPE'(5'd9);
    localparam logic [NB_OPE-1:0] ALU_SRA  = NB_OPE'(5'd10);
    localparam logic [NB_OPE-1:0] ALU_NOR  = NB_OPE'(5'd12);
    localparam logic [NB_OPE-1:0] ALU_LINK = NB_OPE'(5'd13);
    localparam logic [NB_OPE-1:0] ALU_LUI  = NB_OPE'(5'd14);
    localparam logic [NB_OPE-1:0] ALU_NONE = NB_OPE'(5'd15);

    // R-type function codes (low 6 bits)
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULTU = 6'b011001;
`ifdef ALU_MULDIV_DIV_EN
    localparam logic [5:0] FN_DIVU  = 6'b011011;
`endif
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam int CNT_W = $clog2(NB_DATA);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_DATA - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t               state_r, state_nx_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
    logic [NB_DATA-1:0]   hi_r, hi_nx_s;
    logic [NB_DATA-1:0]   lo_r, lo_nx_s;
    // work_hi/work_lo: partial product (mul) or remainder/quotient (div)
    logic [NB_DATA-1:0]   work_hi_r, work_hi_nx_s;
    logic [NB_DATA-1:0]   work_lo_r, work_lo_nx_s;
    // opnd: multiplicand (mul) or divisor (div)
    logic [NB_DATA-1:0]   opnd_r, opnd_nx_s;

    logic [5:0]           func6_s;
    logic [NB_OPE-1:0]    func_alu_s;
    logic [NB_OPE-1:0]    alu_s;
    logic                 is_func_s;
    logic                 is_mfhi_s, is_mflo_s, is_mthi_s, is_mtlo_s;
    logic                 is_multu_s, is_divu_s, is_hilo_s;
    logic                 busy_s;

    logic [NB_DATA:0]     mul_sum_s;
    logic [2*NB_DATA-1:0] mul_prod_nx_s;

    assign func6_s    = i_function[5:0];
    assign is_func_s  = (i_alu_op_ctl == CTL_FUNC);
    assign is_mfhi_s  = is_func_s && (func6_s == FN_MFHI);
    assign is_mflo_s  = is_func_s && (func6_s == FN_MFLO);
    assign is_mthi_s  = is_func_s && (func6_s == FN_MTHI);
    assign is_mtlo_s  = is_func_s && (func6_s == FN_MTLO);
    assign is_multu_s = is_func_s && (func6_s == FN_MULTU);
`ifdef ALU_MULDIV_DIV_EN
    assign is_divu_s  = is_func_s && (func6_s == FN_DIVU);
`else
    assign is_divu_s  = 1'b0;
`endif
    assign is_hilo_s  = is_mfhi_s | is_mflo_s | is_mthi_s | is_mtlo_s |
                        is_multu_s | is_divu_s;

    assign busy_s     = (state_r != ST_IDLE);
    assign o_busy     = busy_s;
    // Only HI/LO instructions depend on the sequencer; everything else flows
    assign o_stall    = i_valid & is_hilo_s & busy_s;
    assign o_alu      = alu_s;
    assign o_hilo_sel = is_mfhi_s | is_mflo_s;
    assign o_hilo     = is_mfhi_s ? hi_r : lo_r;

    // One shift-add step: add multiplicand when the current multiplier bit
    // is set, then shift the {carry, partial, multiplier} word right.
    assign mul_sum_s     = {1'b0, work_hi_r} +
                           (work_lo_r[0] ? {1'b0, opnd_r} : {(NB_DATA+1){1'b0}});
    assign mul_prod_nx_s = {mul_sum_s, work_lo_r[NB_DATA-1:1]};

`ifdef ALU_MULDIV_DIV_EN
    logic [NB_DATA:0]   div_trial_s;
    logic               div_ge_s;
    logic [NB_DATA-1:0] div_rem_nx_s;
    logic [NB_DATA-1:0] div_quo_nx_s;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. A zero divisor always "fits", which
    // naturally yields quotient all-ones and remainder equal to the dividend.
    assign div_trial_s  = {work_hi_r, work_lo_r[NB_DATA-1]} - {1'b0, opnd_r};
    assign div_ge_s     = ~div_trial_s[NB_DATA];
    assign div_rem_nx_s = div_ge_s ? div_trial_s[NB_DATA-1:0]
                                   : {work_hi_r[NB_DATA-2:0], work_lo_r[NB_DATA-1]};
    assign div_quo_nx_s = {work_lo_r[NB_DATA-2:0], div_ge_s};
`endif

    // Function-field decode for R-type instructions
    always_comb begin
        func_alu_s = ALU_NONE;
        case (func6_s)
            FN_SLL, FN_SLLV: func_alu_s = ALU_SLL;
            FN_SRL, FN_SRLV: func_alu_s = ALU_SRL;
            FN_SRA, FN_SRAV: func_alu_s = ALU_SRA;
            FN_JALR:         func_alu_s = ALU_LINK;
            FN_ADDU:         func_alu_s = ALU_ADD;
            FN_SUBU:         func_alu_s = ALU_SUB;
            FN_AND:          func_alu_s = ALU_AND;
            FN_OR:           func_alu_s = ALU_OR;
            FN_XOR:          func_alu_s = ALU_XOR;
            FN_NOR:          func_alu_s = ALU_NOR;
            FN_SLT:          func_alu_s = ALU_SLT;
            default:         func_alu_s = ALU_NONE;
        endcase
    end

    // Main op-control decode into the ALU operation code
    always_comb begin
        alu_s = ALU_NONE;
        case (i_alu_op_ctl)
            CTL_ADD:  alu_s = ALU_ADD;
            CTL_SUB:  alu_s = ALU_SUB;
            CTL_ANDI: alu_s = ALU_AND;
            CTL_ORI:  alu_s = ALU_OR;
            CTL_XORI: alu_s = ALU_XOR;
            CTL_LUI:  alu_s = ALU_LUI;
            CTL_SLTI: alu_s = ALU_SLT;
            CTL_JAL:  alu_s = ALU_LINK;
            CTL_FUNC: alu_s = func_alu_s;
            default:  alu_s = ALU_NONE;
        endcase
    end

    // Sequencer next-state and HI/LO/datapath next values
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        hi_nx_s      = hi_r;
        lo_nx_s      = lo_r;
        work_hi_nx_s = work_hi_r;
        work_lo_nx_s = work_lo_r;
        opnd_nx_s    = opnd_r;
        case (state_r)
            ST_IDLE: begin
                if (i_valid && is_multu_s) begin
                    state_nx_s   = ST_MUL;
                    cnt_nx_s     = {CNT_W{1'b0}};
                    work_hi_nx_s = {NB_DATA{1'b0}};
                    work_lo_nx_s = i_data_b;
                    opnd_nx_s    = i_data_a;
`ifdef ALU_MULDIV_DIV_EN
                end else if (i_valid && is_divu_s) begin
                    state_nx_s   = ST_DIV;
                    cnt_nx_s     = {CNT_W{1'b0}};
                    work_hi_nx_s = {NB_DATA{1'b0}};
                    work_lo_nx_s = i_data_a;
                    opnd_nx_s    = i_data_b;
`endif
                end else if (i_valid && is_mthi_s) begin
                    hi_nx_s = i_data_a;
                end else if (i_valid && is_mtlo_s) begin
                    lo_nx_s = i_data_a;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                work_hi_nx_s = mul_prod_nx_s[2*NB_DATA-1:NB_DATA];
                work_lo_nx_s = mul_prod_nx_s[NB_DATA-1:0];
                cnt_nx_s     = cnt_r + CNT_W'(1'b1);
                if (cnt_r == CNT_LAST) begin
                    hi_nx_s    = mul_prod_nx_s[2*NB_DATA-1:NB_DATA];
                    lo_nx_s    = mul_prod_nx_s[NB_DATA-1:0];
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
`ifdef ALU_MULDIV_DIV_EN
            ST_DIV: begin
                work_hi_nx_s = div_rem_nx_s;
                work_lo_nx_s = div_quo_nx_s;
                cnt_nx_s     = cnt_r + CNT_W'(1'b1);
                if (cnt_r == CNT_LAST) begin
                    hi_nx_s    = div_rem_nx_s;
                    lo_nx_s    = div_quo_nx_s;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
`endif
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset wins over accept and completion
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {NB_DATA{1'b0}};
            lo_r      <= {NB_DATA{1'b0}};
            work_hi_r <= {NB_DATA{1'b0}};
            work_lo_r <= {NB_DATA{1'b0}};
            opnd_r    <= {NB_DATA{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            hi_r      <= hi_nx_s;
            lo_r      <= lo_nx_s;
            work_hi_r <= work_hi_nx_s;
            work_lo_r <= work_lo_nx_s;
            opnd_r    <= opnd_nx_s;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_ctl.sv
// Directed bench for alu_muldiv_ctl. Expected outputs are queued when each
// stimulus step is driven and popped/compared at the following falling edge.
// Division expectations follow the ALU_MULDIV_DIV_EN build option.
module tb_alu_muldiv_ctl;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_FUNC = 4'b0010;
    localparam logic [3:0] C_ANDI = 4'b0100;
    localparam logic [3:0] C_ORI  = 4'b0101;
    localparam logic [3:0] C_XORI = 4'b0110;
    localparam logic [3:0] C_LUI  = 4'b0111;
    localparam logic [3:0] C_SLTI = 4'b1000;
    localparam logic [3:0] C_JAL  = 4'b1001;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADDU  = 6'b100001;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [3:0]  i_alu_op_ctl;
    logic [5:0]  i_function;
    logic        i_valid;
    logic [31:0] i_data_a, i_data_b;
    logic [4:0]  o_alu;
    logic        o_hilo_sel;
    logic [31:0] o_hilo;
    logic        o_stall, o_busy;

    alu_muldiv_ctl dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_alu_op_ctl(i_alu_op_ctl),
        .i_function  (i_function),
        .i_valid     (i_valid),
        .i_data_a    (i_data_a),
        .i_data_b    (i_data_b),
        .o_alu       (o_alu),
        .o_hilo_sel  (o_hilo_sel),
        .o_hilo      (o_hilo),
        .o_stall     (o_stall),
        .o_busy      (o_busy)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [4:0]  alu;
        logic        sel;
        logic [31:0] hilo;
        logic        chk_hilo;
        logic        stall;
        logic        busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    localparam int N_DC = 26;
    logic [3:0] dc_ctl [N_DC] = '{
        C_FUNC, C_FUNC, C_SLTI, C_LUI, C_FUNC, C_ADD, C_SUB, C_ANDI, C_ORI,
        C_XORI, C_JAL, C_FUNC, C_FUNC, C_FUNC, C_FUNC, C_FUNC, C_FUNC, C_FUNC,
        C_FUNC, C_FUNC, C_FUNC, C_FUNC, C_FUNC, 4'b1111, 4'b0011, C_FUNC};
    logic [5:0] dc_fn [N_DC] = '{
        F_ADDU, 6'b100111, 6'b000000, 6'b000000, 6'b001000, F_MULTU, 6'b000000,
        6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000100,
        6'b000010, 6'b000110, 6'b000011, 6'b000111, 6'b001001, 6'b100011,
        6'b100100, 6'b100101, 6'b100110, 6'b101010, F_ADDU, F_ADDU, 6'b111111};
    logic [4:0] dc_alu [N_DC] = '{
        5'd2, 5'd12, 5'd7, 5'd14, 5'd15, 5'd2, 5'd6, 5'd0, 5'd1, 5'd3, 5'd13,
        5'd8, 5'd8, 5'd9, 5'd9, 5'd10, 5'd10, 5'd13, 5'd6, 5'd0, 5'd1, 5'd3,
        5'd7, 5'd15, 5'd15, 5'd15};

    // Drive one cycle of stimulus, queue its expectation, compare at negedge.
    task automatic vec(input string tag, input logic [3:0] ctl, input logic [5:0] fn,
                       input logic valid, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] e_alu, input logic e_sel, input logic [31:0] e_hilo,
                       input logic e_chk, input logic e_stall, input logic e_busy);
        exp_t  e;
        string t;
        i_alu_op_ctl = ctl;
        i_function   = fn;
        i_valid      = valid;
        i_data_a     = a;
        i_data_b     = b;
        exp_q.push_back('{alu: e_alu, sel: e_sel, hilo: e_hilo, chk_hilo: e_chk,
                          stall: e_stall, busy: e_busy});
        tag_q.push_back(tag);
        @(negedge i_clock);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        assert (o_alu === e.alu) else begin
            n_err++;
            $error("FAIL %s o_alu observed %0d expected %0d", t, o_alu, e.alu);
        end
        n_vec++;
        assert (o_hilo_sel === e.sel) else begin
            n_err++;
            $error("FAIL %s o_hilo_sel observed %0b expected %0b", t, o_hilo_sel, e.sel);
        end
        n_vec++;
        assert (o_stall === e.stall) else begin
            n_err++;
            $error("FAIL %s o_stall observed %0b expected %0b", t, o_stall, e.stall);
        end
        n_vec++;
        assert (o_busy === e.busy) else begin
            n_err++;
            $error("FAIL %s o_busy observed %0b expected %0b", t, o_busy, e.busy);
        end
        if (e.chk_hilo) begin
            n_vec++;
            assert (o_hilo === e.hilo) else begin
                n_err++;
                $error("FAIL %s o_hilo observed %h expected %h", t, o_hilo, e.hilo);
            end
        end
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    initial begin
        logic [63:0] p;
        logic [31:0] ma, mb;

        // reset for two edges with a bubble on the inputs
        i_reset = 1'b1; i_alu_op_ctl = C_ADD; i_function = 6'b0; i_valid = 1'b0;
        i_data_a = 32'h0; i_data_b = 32'h0;
        @(posedge i_clock); @(posedge i_clock); #1;
        i_reset = 1'b0;

        vec("rst_mfhi", C_FUNC, F_MFHI, 1'b0, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        vec("rst_mflo", C_FUNC, F_MFLO, 1'b0, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

        // ALU decode table
        for (int i = 0; i < N_DC; i++)
            vec($sformatf("dec%0d", i), dc_ctl[i], dc_fn[i], 1'b1, 32'h0, 32'h0,
                dc_alu[i], 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // MTHI/MTLO and bubbles
        vec("mthi", C_FUNC, F_MTHI, 1'b1, 32'h12345678, 32'h0, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vec("mfhi_mt", C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
        vec("mtlo_bub", C_FUNC, F_MTLO, 1'b0, 32'hDEADBEEF, 32'h0, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vec("mflo_bub", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        vec("mtlo", C_FUNC, F_MTLO, 1'b1, 32'hCAFEF00D, 32'h0, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vec("mflo_mt", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
        vec("multu_bub", C_FUNC, F_MULTU, 1'b0, 32'h3, 32'h3, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vec("after_bub", C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);

        // MULTU 0xFFFFFFFF * 2 with MFHI waiting behind it
        ma = 32'hFFFFFFFF; mb = 32'h00000002; p = 64'(ma) * 64'(mb);
        vec("mul1_acc", C_FUNC, F_MULTU, 1'b1, ma, mb, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++)
            vec($sformatf("mul1_stall%0d", k), C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0,
                5'd15, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        vec("mul1_hi", C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, p[63:32], 1'b1, 1'b0, 1'b0);
        vec("mul1_lo", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, p[31:0], 1'b1, 1'b0, 1'b0);

        // MULTU in flight: unrelated ADDU and bubble MFLO never stall
        ma = 32'h00010003; mb = 32'h00000005; p = 64'(ma) * 64'(mb);
        vec("mul2_acc", C_FUNC, F_MULTU, 1'b1, ma, mb, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            if (k % 2 == 0)
                vec($sformatf("mul2_addu%0d", k), C_FUNC, F_ADDU, 1'b1, 32'h1, 32'h2,
                    5'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            else
                vec($sformatf("mul2_bub%0d", k), C_FUNC, F_MFLO, 1'b0, 32'h0, 32'h0,
                    5'd15, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        vec("mul2_lo", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, p[31:0], 1'b1, 1'b0, 1'b0);
        vec("mul2_hi", C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, p[63:32], 1'b1, 1'b0, 1'b0);

        // Stalled MTHI is re-presented and accepted once idle
        ma = 32'h3; mb = 32'h4; p = 64'(ma) * 64'(mb);
        vec("mul3_acc", C_FUNC, F_MULTU, 1'b1, ma, mb, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++)
            vec($sformatf("mthi_stall%0d", k), C_FUNC, F_MTHI, 1'b1, 32'h0000AAAA, 32'h0,
                5'd15, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        vec("mthi_go", C_FUNC, F_MTHI, 1'b1, 32'h0000AAAA, 32'h0, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vec("mul3_hi", C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0000AAAA, 1'b1, 1'b0, 1'b0);
        vec("mul3_lo", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, p[31:0], 1'b1, 1'b0, 1'b0);

`ifdef ALU_MULDIV_DIV_EN
        // DIVU 100/7, 5/0 and an irregular pair
        for (int d = 0; d < 3; d++) begin
            ma = (d == 0) ? 32'd100 : (d == 1) ? 32'd5 : 32'hDEADBEEF;
            mb = (d == 0) ? 32'd7   : (d == 1) ? 32'd0 : 32'h00001234;
            vec($sformatf("div%0d_acc", d), C_FUNC, F_DIVU, 1'b1, ma, mb,
                5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 32; k++)
                vec($sformatf("div%0d_stall%0d", d, k), C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0,
                    5'd15, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
            vec($sformatf("div%0d_lo", d), C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1,
                (mb == 32'd0) ? 32'hFFFFFFFF : ma / mb, 1'b1, 1'b0, 1'b0);
            vec($sformatf("div%0d_hi", d), C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1,
                (mb == 32'd0) ? ma : ma % mb, 1'b1, 1'b0, 1'b0);
        end
`else
        // Without the divider DIVU is inert: no busy, no stall, HI/LO kept
        vec("divu_acc", C_FUNC, F_DIVU, 1'b1, 32'd100, 32'd7, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vec("divu_lo", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'd12, 1'b1, 1'b0, 1'b0);
        vec("divu0_acc", C_FUNC, F_DIVU, 1'b1, 32'd5, 32'd0, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vec("divu0_hi", C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0000AAAA, 1'b1, 1'b0, 1'b0);
        vec("divu0_lo", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'd12, 1'b1, 1'b0, 1'b0);
`endif

        // Reset in the tenth busy cycle of a MULTU aborts it
        vec("mul4_acc", C_FUNC, F_MULTU, 1'b1, 32'd7, 32'd9, 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++)
            vec($sformatf("mul4_stall%0d", k), C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0,
                5'd15, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        i_reset = 1'b1;
        vec("mul4_rstcyc", C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        i_reset = 1'b0;
        vec("rst_abort_hi", C_FUNC, F_MFHI, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        vec("rst_abort_lo", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 24; k++)
            vec($sformatf("rst_quiet%0d", k), C_FUNC, F_ADDU, 1'b1, 32'h0, 32'h0,
                5'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vec("rst_final_lo", C_FUNC, F_MFLO, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
